// File: rtl/alu_ctrl_seq.sv
// Hack CPU ALU control sequencer: latches one instruction, drives the external ALU, returns a registered result.
// Latency 2 cycles (C-instr) / 1 cycle (A-instr) accept-to-result; a stalled result holds until res_ready, no new accept meanwhile.
module alu_ctrl_seq (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] instr,
  input  logic [15:0] a_reg,
  input  logic [15:0] d_reg,
  input  logic [15:0] m_in,
  output logic [15:0] alu_x,
  output logic [15:0] alu_y,
  output logic        zx,
  output logic        nx,
  output logic        zy,
  output logic        ny,
  output logic        f,
  output logic        no,
  input  logic [15:0] alu_out,
  input  logic        alu_zr,
  input  logic        alu_ng,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic [2:0]  res_dest,
  output logic        res_jump,
  output logic        res_zr,
  output logic        res_ng,
  output logic [15:0] txn_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t      r_state, w_next;
  logic [12:0] r_instr;
  logic [15:0] r_a, r_d, r_m;
  logic [15:0] r_res_data;
  logic [2:0]  r_res_dest;
  logic        r_res_jump, r_res_zr, r_res_ng;
  logic [15:0] r_txn;
  logic        w_accept, w_issue, w_handoff;
  // instr[14:13] have no meaning in a Hack C-instruction
  logic        w_unused_bits;

  assign w_unused_bits = ^instr[14:13];

  assign in_ready  = (r_state == IDLE);
  assign w_issue   = (r_state == ISSUE);
  assign res_valid = (r_state == RESP);
  assign w_accept  = in_valid && in_ready;
  assign w_handoff = res_valid && res_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next = instr[15] ? ISSUE : RESP;
      ISSUE:   w_next = RESP;
      RESP:    if (res_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign {zx, nx, zy, ny, f, no} = w_issue ? r_instr[11:6] : 6'b0;
  assign alu_x = w_issue ? r_d : 16'h0000;
  assign alu_y = w_issue ? (r_instr[12] ? r_m : r_a) : 16'h0000;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_instr    <= '0;
      r_a        <= '0;
      r_d        <= '0;
      r_m        <= '0;
      r_res_data <= '0;
      r_res_dest <= '0;
      r_res_jump <= 1'b0;
      r_res_zr   <= 1'b0;
      r_res_ng   <= 1'b0;
      r_txn      <= '0;
    end else begin
      if (w_accept) begin
        r_instr <= instr[12:0];
        r_a     <= a_reg;
        r_d     <= d_reg;
        r_m     <= m_in;
        if (!instr[15]) begin
          r_res_data <= instr;
          r_res_dest <= 3'b100;
          r_res_jump <= 1'b0;
          r_res_zr   <= 1'b0;
          r_res_ng   <= 1'b0;
        end
      end
      // ALU result and flags are sampled on the single ISSUE cycle
      if (w_issue) begin
        r_res_data <= alu_out;
        r_res_zr   <= alu_zr;
        r_res_ng   <= alu_ng;
        r_res_dest <= r_instr[5:3];
        r_res_jump <= (r_instr[2] & alu_ng) | (r_instr[1] & alu_zr) |
                      (r_instr[0] & ~alu_zr & ~alu_ng);
      end
      if (w_handoff) r_txn <= r_txn + 16'd1;
    end
  end

  assign res_data  = r_res_data;
  assign res_dest  = r_res_dest;
  assign res_jump  = r_res_jump;
  assign res_zr    = r_res_zr;
  assign res_ng    = r_res_ng;
  assign txn_count = r_txn;

endmodule

// File: doc/alu_ctrl_seq.md
ALU_CTRL_SEQ -- requirements
Module: alu_ctrl_seq

Interface
REQ-001 SHALL have ports (name  direction  width  meaning), clock and reset first, as listed below.
- clock  in  1  single clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  instruction offered.
- in_ready  out  1  block can accept an instruction.
- instr  in  16  Hack instruction.
- a_reg  in  16  A operand.
- d_reg  in  16  D operand.
- m_in  in  16  M operand.
- alu_x  out  16  ALU x input.
- alu_y  out  16  ALU y input.
- zx, nx, zy, ny, f, no  out  1 each  ALU control bits.
- alu_out  in  16  ALU result.
- alu_zr  in  1  ALU zero flag.
- alu_ng  in  1  ALU negative flag.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_data  out  16  result value.
- res_dest  out  3  {A, D, M} write enables.
- res_jump  out  1  jump taken.
- res_zr  out  1  captured zero flag.
- res_ng  out  1  captured negative flag.
- txn_count  out  16  completed transactions.
REQ-002 SHALL use one clock and an asynchronous active-low reset_n (clock `clock`, reset `reset_n`); no parameters.

Function
REQ-003 SHALL implement FSM states IDLE, ISSUE, RESP.
REQ-004 SHALL assert in_ready only in IDLE.
REQ-005 SHALL accept when in_valid && in_ready; on that edge latch instr, a_reg, d_reg and m_in.
REQ-006 Accepted C-instruction (instr[15]=1): IDLE->ISSUE; A-instruction (instr[15]=0): IDLE->RESP directly.
REQ-007 In ISSUE:
- drive {zx,nx,zy,ny,f,no} = latched instr[11:6];
- alu_x = latched d_reg;
- alu_y = latched instr[12] ? latched m_in : latched a_reg.
REQ-008 Outside ISSUE, the six control bits SHALL be 0; alu_x/alu_y SHALL be 0.
REQ-009 On the ISSUE->RESP edge, SHALL register:
- res_data = alu_out; res_zr = alu_zr; res_ng = alu_ng;
- res_dest = instr[5:3];
- res_jump = (instr[2]&ng) | (instr[1]&zr) | (instr[0]&~zr&~ng).
REQ-010 On an A-instruction accept edge, SHALL register res_data = instr, res_dest = 3'b100, res_jump = 0, res_zr = 0, res_ng = 0.
REQ-011 SHALL assert res_valid only in RESP.
REQ-012 SHALL hold all res_* outputs stable while res_valid && !res_ready.
REQ-013 On res_valid && res_ready: RESP->IDLE and txn_count += 1 (mod 2^16, 0xFFFF wraps to 0x0000).
REQ-014 Latency from accept edge to res_valid high SHALL be 2 cycles for C-instructions and 1 cycle for A-instructions.
REQ-015 Maximum throughput SHALL be one C-instruction per 3 cycles; no new accept in the same cycle as a result handoff.
REQ-016 in_valid while not in IDLE SHALL be ignored; instr and operands are sampled only at accept.
REQ-017 instr[14:13] SHALL be ignored.

Reset
REQ-018 While reset_n=0, the block SHALL immediately (asynchronously) force:
- state IDLE;
- in_ready=1;
- res_valid=0 and every other output 0;
- txn_count=0.
REQ-019 Reset asserted in ISSUE or RESP SHALL discard the in-flight instruction without incrementing txn_count.
REQ-020 First accept SHALL be possible on the first rising edge with reset_n=1.

Verification
REQ-021 Bench SHALL use a reference Hack ALU model and cover these directed scenarios:
- D=9, A=15, instr=0xE090 (D=D+A) -> ISSUE controls 000010, alu_x=9, alu_y=15; res_data=24, res_dest=010, res_jump=0, res_valid 2 cycles after accept, txn_count=1.
- D=9, A=15, instr=0xE4C4 (D-A; JLT) -> controls 010011, res_data=-6 (0xFFFA), res_ng=1, res_zr=0, res_jump=1, res_dest=000.
- M=9, instr=0xFC88 (M=M-1; a=1) -> alu_y=m_in, res_data=8, res_dest=001.
- instr=0x1234 -> res_data=0x1234, res_dest=100, res_jump=0, controls stay 000000, res_valid 1 cycle after accept.
- Backpressure: res_ready=0 for 5 cycles -> res_* constant, in_ready=0, in_valid ignored; release -> IDLE next edge.
- reset_n pulsed low during ISSUE -> outputs 0 and in_ready=1 immediately, txn_count=0, next instruction completes normally.
